// File: rtl/nn_pkg.sv
// Shared fixed-point defaults and saturation helpers for the neuron datapath.
package nn_pkg;

    // Default Q3.5 operand format.
    localparam int FRAC_BITS_DEF = 5;
    localparam int Q_WIDTH_DEF   = 8;

    // Working width for lossless intermediate sums; all datapath widths
    // are expected to stay well below this.
    localparam int WIDE = 64;

    // Largest value representable in a signed field of 'width' bits.
    function automatic logic signed [WIDE-1:0] max_of(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [WIDE-1:0] saturate(
        input logic signed [WIDE-1:0] value,
        input int                     width
    );
        logic signed [WIDE-1:0] hi;
        logic signed [WIDE-1:0] lo;
        hi = max_of(width);
        lo = -hi - 64'sd1;
        if (value > hi)      return hi;
        else if (value < lo) return lo;
        else                 return value;
    endfunction

    // True when saturate() would have to clamp the value.
    function automatic logic clamps(
        input logic signed [WIDE-1:0] value,
        input int                     width
    );
        logic signed [WIDE-1:0] hi;
        hi = max_of(width);
        return (value > hi) || (value < (-hi - 64'sd1));
    endfunction

endpackage

// File: rtl/relu.sv
// Rectified linear unit: negative inputs map to zero, others pass through.
module relu #(
    parameter int WIDTH = 11
) (
    input  logic signed [WIDTH-1:0] value,
    output logic signed [WIDTH-1:0] result
);

    assign result = value[WIDTH-1] ? '0 : value;

endmodule

// File: rtl/perceptron_mac.sv
// Single-neuron multiply-accumulate with saturating accumulator, sticky
// overflow flag and a combinational biased (optionally rectified) output.
module perceptron_mac
    import nn_pkg::*;
#(
    parameter int INPUT_WIDTH  = Q_WIDTH_DEF,
    parameter int WEIGHT_WIDTH = Q_WIDTH_DEF,
    parameter int FRAC_BITS    = FRAC_BITS_DEF,
    parameter int SUM_WIDTH    = INPUT_WIDTH + 3,
    parameter int USE_RELU     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic signed [INPUT_WIDTH-1:0]  data_in,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    input  logic signed [WEIGHT_WIDTH-1:0] bias,
    output logic signed [SUM_WIDTH-1:0]    sum,
    output logic signed [SUM_WIDTH-1:0]    act,
    output logic                           ovf
);

    localparam int PROD_WIDTH = INPUT_WIDTH + WEIGHT_WIDTH;

    logic signed [PROD_WIDTH-1:0] product;
    logic signed [PROD_WIDTH-1:0] scaled;
    logic signed [WIDE-1:0]       acc_wide;
    logic signed [SUM_WIDTH-1:0]  sum_next;
    logic                         sum_clamped;
    logic signed [WIDE-1:0]       biased_wide;
    logic signed [SUM_WIDTH-1:0]  act_sat;

    // Full-precision product, rescaled by dropping the fraction bits of one
    // operand; the arithmetic shift rounds toward minus infinity.
    assign product = data_in * weight;
    assign scaled  = product >>> FRAC_BITS;

    // Accumulate in a wide field so the clamp sees the true sum.
    assign acc_wide    = WIDE'(sum) + WIDE'(scaled);
    assign sum_next    = SUM_WIDTH'(saturate(acc_wide, SUM_WIDTH));
    assign sum_clamped = clamps(acc_wide, SUM_WIDTH);

    // Accumulator and sticky overflow; clear wins over enable.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            sum <= sum_next;
            if (sum_clamped) ovf <= 1'b1;
        end
    end

    // Bias is added after accumulation; its clamp never touches ovf.
    assign biased_wide = WIDE'(sum) + WIDE'(bias);
    assign act_sat     = SUM_WIDTH'(saturate(biased_wide, SUM_WIDTH));

    if (USE_RELU != 0) begin : g_relu
        relu #(.WIDTH(SUM_WIDTH)) u_relu (
            .value  (act_sat),
            .result (act)
        );
    end else begin : g_linear
        assign act = act_sat;
    end

endmodule

// File: tb/tb_perceptron_mac.sv
// Self-checking bench: directed corner cases plus randomized MAC traffic
// compared against an integer-arithmetic model of the neuron.
module tb_perceptron_mac;

    localparam int SUM_W   = 11;
    localparam int SCALE   = 32;
    localparam int SUM_MAX = 1023;
    localparam int SUM_MIN = -1024;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic              en  = 1'b0;
    logic signed [7:0] data_in = '0;
    logic signed [7:0] weight  = '0;
    logic signed [7:0] bias    = '0;

    logic signed [SUM_W-1:0] sum_lin, act_lin, sum_rel, act_rel;
    logic                    ovf_lin, ovf_rel;

    int checks = 0;
    int passed = 0;

    // Reference model state.
    int exp_sum = 0;
    bit exp_ovf = 1'b0;

    always #5 clk = ~clk;

    perceptron_mac #(.USE_RELU(0)) dut_lin (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .data_in(data_in), .weight(weight), .bias(bias),
        .sum(sum_lin), .act(act_lin), .ovf(ovf_lin)
    );

    perceptron_mac #(.USE_RELU(1)) dut_rel (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .data_in(data_in), .weight(weight), .bias(bias),
        .sum(sum_rel), .act(act_rel), .ovf(ovf_rel)
    );

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    endtask

    function automatic int floor_div(input int p);
        if (p >= 0) return p / SCALE;
        return -((-p + SCALE - 1) / SCALE);
    endfunction

    function automatic int clamp(input int v);
        if (v > SUM_MAX) return SUM_MAX;
        if (v < SUM_MIN) return SUM_MIN;
        return v;
    endfunction

    // Compare every DUT output against the model.
    task automatic check_all(input string tag);
        int a;
        a = clamp(exp_sum + int'(bias));
        check({tag, ".sum"}, int'(sum_lin), exp_sum);
        check({tag, ".ovf"}, int'(ovf_lin), int'(exp_ovf));
        check({tag, ".act"}, int'(act_lin), a);
        check({tag, ".sum_r"}, int'(sum_rel), exp_sum);
        check({tag, ".act_r"}, int'(act_rel), (a < 0) ? 0 : a);
    endtask

    // One clock: drive on the falling edge, model on the rising edge,
    // compare shortly after.
    task automatic cycle(input bit e, input bit c, input int d, input int w,
                         input int b, input string tag);
        int t;
        @(negedge clk);
        en = e; clr = c;
        data_in = 8'(d); weight = 8'(w); bias = 8'(b);
        @(posedge clk);
        if (c) begin
            exp_sum = 0;
            exp_ovf = 1'b0;
        end else if (e) begin
            t = exp_sum + floor_div(int'(data_in) * int'(weight));
            if (t != clamp(t)) exp_ovf = 1'b1;
            exp_sum = clamp(t);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset state: act reflects the saturated (rectified) bias alone.
        bias = -8'sd20;
        #12;
        check_all("reset_neg_bias");
        bias = 8'sd50;
        #1;
        check_all("reset_pos_bias");
        @(negedge clk);
        rst = 1'b1;

        // 1.0 * 1.0 = 1.0
        cycle(1, 0, 32, 32, 0, "one_by_one");
        cycle(0, 0, 5, 7, 0, "hold");

        // Truncation toward minus infinity.
        cycle(0, 1, 0, 0, 0, "clear");
        cycle(1, 0, -32, 16, 0, "neg_half");
        cycle(1, 0, -1, 1, 0, "neg_lsb");

        // Bias and ReLU on a negative sum.
        cycle(0, 0, 0, 0, 8, "relu_bias8");
        cycle(0, 0, 0, 0, 32, "relu_bias32");
        cycle(0, 0, 0, 0, -128, "bias_min");

        // Saturation and sticky overflow.
        cycle(0, 1, 0, 0, 0, "clear2");
        cycle(1, 0, 127, 127, 0, "sat1");
        cycle(1, 0, 127, 127, 0, "sat2");
        cycle(1, 0, 127, 127, 0, "sat3");
        cycle(1, 0, -32, 32, 127, "ovf_sticky_act_sat");
        cycle(0, 1, 127, 127, 0, "clr_after_ovf");

        // Clear beats a simultaneous enable.
        cycle(1, 0, 32, 32, 0, "pre_clr_en");
        cycle(1, 1, 32, 32, 0, "clr_and_en");

        // Negative saturation.
        for (int i = 0; i < 9; i++) cycle(1, 0, -128, 127, 0, "neg_sat");

        // Asynchronous reset mid-accumulation, checked before the next edge.
        cycle(0, 1, 0, 0, 0, "clear3");
        cycle(1, 0, 100, 50, 0, "pre_reset");
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b0;
        exp_sum = 0;
        exp_ovf = 1'b0;
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 0, 32, 32, 0, "after_reset");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            bit e, c;
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            cycle(e, c, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/perceptron_mac.md
PERCEPTRON_MAC -- requirements
Module: perceptron_mac

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 8, signed data_in width in fixed point with FRAC_BITS fraction bits.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, signed weight and bias width (Q3.5 at default).
REQ-003 SHALL have parameter FRAC_BITS, default 5, fraction bits shared by data_in, weight, bias, sum and act.
REQ-004 SHALL have parameter SUM_WIDTH, default INPUT_WIDTH+3, accumulator and output width.
REQ-005 SHALL have parameter USE_RELU, default 0; 1 applies ReLU on act.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port clr, input, 1, synchronous accumulator clear.
REQ-009 SHALL have port en, input, 1, accumulate enable.
REQ-010 SHALL have port data_in, input, INPUT_WIDTH, signed operand.
REQ-011 SHALL have port weight, input, WEIGHT_WIDTH, signed operand.
REQ-012 SHALL have port bias, input, WEIGHT_WIDTH, signed bias.
REQ-013 SHALL have port sum, output, SUM_WIDTH, signed registered accumulator.
REQ-014 SHALL have port act, output, SUM_WIDTH, signed activation.
REQ-015 SHALL have port ovf, output, 1, sticky saturation flag.

Function
REQ-016 Rising clk with en=1, clr=0: product = data_in*weight at full INPUT_WIDTH+WEIGHT_WIDTH signed precision.
REQ-017 Scaled term = product arithmetically shifted right FRAC_BITS (truncation toward minus infinity).
REQ-018 Accumulator SHALL update to sum + scaled term, computed without loss, then saturated to SUM_WIDTH signed range.
REQ-019 When the REQ-018 saturation clamps, ovf SHALL set on that edge and hold until clr or reset.
REQ-020 en=0, clr=0: sum and ovf hold.
REQ-021 clr=1: sum and ovf clear to 0 on that edge; clr has priority over simultaneous en.
REQ-022 Latency: sum reflects an enabled operand pair one cycle after the sampling edge; one MAC per cycle, back-to-back, no stall.
REQ-023 act SHALL be combinational: sum + sign-extended bias, computed one bit wider, saturated to SUM_WIDTH.
REQ-024 USE_RELU=1: negative act SHALL be replaced by 0; non-negative passes unchanged.
REQ-025 USE_RELU=0: act SHALL be the saturated biased sum.
REQ-026 act saturation SHALL NOT set ovf.

Reset
REQ-027 rst low SHALL asynchronously force sum=0 and ovf=0.
REQ-028 act under reset equals relu/saturate(bias).
REQ-029 Reset mid-accumulation SHALL discard the partial sum; first en edge after release starts from 0.

Structure
REQ-030 Fixed-point defaults (FRAC_BITS=5, Q3.5 operand width 8) and saturate helper SHALL live in shared package nn_pkg.
REQ-031 ReLU SHALL be sub-module relu (parameter WIDTH, combinational, negative in -> 0 out); no other sub-modules.
REQ-032 No memories, latches or multicycle paths; one signed multiplier.

Verification
REQ-033 Defaults, en one cycle, data_in=32, weight=32, bias=0 -> sum=32, act=32, ovf=0.
REQ-034 data_in=-32, weight=16 -> sum=-16; next cycle data_in=-1, weight=1 -> sum=-17 (truncation toward minus infinity).
REQ-035 data_in=127, weight=127 for 3 cycles -> sum 504, 1008, 1023; ovf=1 after third edge; clr -> sum=0, ovf=0.
REQ-036 USE_RELU=1, sum=-16, bias=8 -> act=0; bias=32 -> act=16.
REQ-037 en=1 and clr=1 together after sum=32 -> sum=0; rst low mid-run asynchronously -> sum=0 before next edge.
